nibble_adder_seq: RTL and testbench
===================================

Name: nibble_adder_seq

Overview:
- Multi-precision add/subtract sequencer. It reuses one 4-bit adder slice to add or subtract WIDTH-bit operands, one nibble per clock, LSB nibble first, with a registered carry chain between nibbles.
- It sits between a requesting controller (start/done handshake) and the nibble-wide adder datapath.
- It trades latency for area: WIDTH/4 adder cycles per operation instead of a full-width adder.

Parameters:
- WIDTH, 16, operand/result width in bits. Must be a multiple of 4 and at least 4; elaboration error otherwise.
- NIB, WIDTH/4, derived number of nibble steps. Localparam, not overridable.

Ports:
- clk  input  1  rising-edge clock; sole clock domain.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request pulse. Sampled only when busy=0.
- op_sub  input  1  0 = A+B, 1 = A-B. Sampled with start.
- a_in  input  WIDTH  operand A. Sampled with start.
- b_in  input  WIDTH  operand B. Sampled with start.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse when the result becomes valid.
- result  output  WIDTH  last completed sum/difference. Holds between operations.
- cout  output  1  final carry out. For SUB, 1 means no borrow.
- overflow  output  1  two's-complement signed overflow of the last operation.

Behaviour:
- Reset: rst=1 at a rising edge forces state=IDLE. It clears busy, done, result, cout, overflow, the nibble counter, the carry register and the working registers. Reset has priority over every other event.
- States:
  - IDLE: accepts a request.
  - RUN: one nibble per cycle.
  - DONE: one cycle; done=1.
- IDLE -> RUN: start=1 sampled. At that edge the block latches A, B_eff and op, sets the carry register to op_sub, and sets counter=0.
  - B_eff = b_in for ADD, ~b_in for SUB (two's complement via inverted B plus carry-in 1).
- RUN, each cycle:
  - Nibble i of the working sum = A[4i+3:4i] + B_eff[4i+3:4i] + carry.
  - The carry register takes that nibble's carry out.
  - counter increments.
  - After nibble NIB-1 -> DONE.
- Entering DONE:
  - result <= full working sum.
  - cout <= final carry.
  - overflow <= (A[MSB] == B_eff[MSB]) && (sum[MSB] != A[MSB]).
- DONE -> IDLE when start=0. DONE -> RUN when start=1: back-to-back request, latched as in IDLE.
- Latency: start high in cycle 0 gives done high in cycle NIB+1 (cycle 5 for WIDTH=16). Throughput is one operation per NIB+1 cycles.
- start while busy=1 is ignored; no queuing, no error flag. Operand changes during RUN have no effect.
- result, cout and overflow change only on entry to DONE. Intermediate nibbles are never visible on result.
- WIDTH=4 (NIB=1): RUN lasts exactly one cycle.
- Carry wrap: the carry out of the top nibble goes only to cout. It is never fed back.
- rst during RUN or DONE: abort immediately, no done pulse, outputs zeroed.

Decomposition:
- Shared package/include adder_seq_defs:
  - state encodings ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2;
  - OP_ADD=1'b0, OP_SUB=1'b1;
  - nibble width constant NIB_W=4.
- One sub-module: nibble_add_cin. Purely combinational; inputs a[3:0], b[3:0], cin; outputs sum[3:0], cout. Instantiated once.
- FSM, counter, carry register and working registers live in nibble_adder_seq.

Test Plan (WIDTH=16):
- rst=1 for 2 cycles -> busy=0, done=0, result=0x0000, cout=0, overflow=0.
- ADD 0x00FF+0x0001, start in cycle 0 -> busy high cycles 1-4; done pulse in cycle 5 only; result=0x0100, cout=0, overflow=0.
- ADD 0xFFFF+0x0001 -> result=0x0000, cout=1, overflow=0. ADD 0x7FFF+0x0001 -> result=0x8000, cout=0, overflow=1.
- SUB 0x8000-0x0001 -> result=0x7FFF, cout=1, overflow=1. SUB 0x0003-0x0005 -> result=0xFFFE, cout=0, overflow=0.
- start re-pulsed with new operands during RUN -> ignored; first result returned unchanged. start held in the DONE cycle with 0x1234+0x1111 -> next done 5 cycles later, result=0x2345.
- rst asserted in cycle 3 of RUN -> no done pulse, all outputs 0. A fresh start afterwards completes normally.

Source files
------------

// File: rtl/adder_seq_defs.sv
// adder_seq_defs: shared state encodings and constants for the nibble add/sub sequencer
package adder_seq_defs;
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;
  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;
  localparam int NIB_W = 4;
endpackage

// File: rtl/nibble_add_cin.sv
// nibble_add_cin: combinational 4-bit adder slice with carry in and carry out
module nibble_add_cin
  import adder_seq_defs::*;
(
  input  logic [NIB_W-1:0] a,
  input  logic [NIB_W-1:0] b,
  input  logic             cin,
  output logic [NIB_W-1:0] sum,
  output logic             cout
);
  assign {cout, sum} = (NIB_W + 1)'(a) + (NIB_W + 1)'(b) + (NIB_W + 1)'(cin);
endmodule

// File: rtl/nibble_adder_seq.sv
// nibble_adder_seq: WIDTH-bit add/subtract computed one nibble per clock through a shared 4-bit slice
module nibble_adder_seq
  import adder_seq_defs::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             op_sub,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             overflow
);
  localparam int NIB = WIDTH / NIB_W;
  localparam int CW = NIB > 1 ? $clog2(NIB) : 1;
  localparam int IW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(NIB - 1);
  if (WIDTH % NIB_W != 0 || WIDTH < NIB_W) begin : g_bad_width
    $error("nibble_adder_seq: WIDTH must be a positive multiple of 4");
  end
  state_t state;
  logic [WIDTH-1:0] a_r, b_r, sum_r, sum_nx;
  logic [CW-1:0] cnt;
  logic [IW-1:0] idx;
  logic carry, s_co;
  logic [NIB_W-1:0] s;
  assign idx = IW'(NIB_W * int'(cnt));
  nibble_add_cin u_add (
    .a   (a_r[idx +: NIB_W]),
    .b   (b_r[idx +: NIB_W]),
    .cin (carry),
    .sum (s),
    .cout(s_co)
  );
  // working sum with the nibble being computed this cycle merged in
  always_comb begin
    sum_nx = sum_r;
    sum_nx[idx +: NIB_W] = s;
  end
  // sequencer: latch operands, step through nibbles, publish the result on entry to DONE
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      result   <= '0;
      cout     <= 1'b0;
      overflow <= 1'b0;
      cnt      <= '0;
      carry    <= 1'b0;
      a_r      <= '0;
      b_r      <= '0;
      sum_r    <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state <= ST_RUN;
            busy  <= 1'b1;
            a_r   <= a_in;
            b_r   <= op_sub == OP_SUB ? ~b_in : b_in;
            carry <= op_sub;
            cnt   <= '0;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_RUN: begin
          sum_r <= sum_nx;
          carry <= s_co;
          cnt   <= cnt + 1'b1;
          if (cnt == LAST) begin
            state    <= ST_DONE;
            busy     <= 1'b0;
            done     <= 1'b1;
            result   <= sum_nx;
            cout     <= s_co;
            overflow <= (a_r[WIDTH-1] == b_r[WIDTH-1]) && (sum_nx[WIDTH-1] != a_r[WIDTH-1]);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_nibble_adder_seq.sv
// tb_nibble_adder_seq: randomized and directed checks of the nibble add/sub sequencer
module tb_nibble_adder_seq;
  logic clk = 1'b0;
  logic rst, start, op_sub;
  logic [15:0] a_in, b_in, result;
  logic busy, done, cout, overflow;
  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  nibble_adder_seq #(.WIDTH(16)) dut (
    .clk(clk), .rst(rst), .start(start), .op_sub(op_sub), .a_in(a_in), .b_in(b_in),
    .busy(busy), .done(done), .result(result), .cout(cout), .overflow(overflow)
  );

  function automatic logic [17:0] model(input logic [15:0] a, input logic [15:0] b, input logic sub);
    int sa, sb, s;
    logic [16:0] w;
    logic c;
    sa = int'($signed(a));
    sb = int'($signed(b));
    s = sub ? sa - sb : sa + sb;
    w = 17'(a) + 17'(b);
    c = sub ? (a >= b) : w[16];
    return {sub ? a - b : a + b, c, (s > 32767) || (s < -32768)};
  endfunction

  task automatic do_op(input logic [15:0] a, input logic [15:0] b, input logic sub,
                       output int lat, output int bcnt);
    @(posedge clk); #1;
    start = 1'b1; a_in = a; b_in = b; op_sub = sub;
    @(posedge clk); #1;
    start = 1'b0; a_in = 16'($urandom); b_in = 16'($urandom); op_sub = 1'($urandom);
    lat = 1; bcnt = 0;
    while (!done && lat < 20) begin
      bcnt += int'(busy);
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; op_sub = 1'b0; a_in = '0; b_in = '0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if ({busy, done, result, cout, overflow} !== 20'h0) begin
      n_fail++;
      $display("FAIL reset: busy=%b done=%b result=%h cout=%b ovf=%b, want all 0", busy, done, result, cout, overflow);
    end
    rst = 1'b0;
  endtask

  task automatic test_directed();
    logic [15:0] va [5] = '{16'h00FF, 16'hFFFF, 16'h7FFF, 16'h8000, 16'h0003};
    logic [15:0] vb [5] = '{16'h0001, 16'h0001, 16'h0001, 16'h0001, 16'h0005};
    logic        vs [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [17:0] ve [5] = '{{16'h0100, 2'b00}, {16'h0000, 2'b10}, {16'h8000, 2'b01},
                           {16'h7FFF, 2'b11}, {16'hFFFE, 2'b00}};
    int lat, bcnt;
    for (int i = 0; i < 5; i++) begin
      do_op(va[i], vb[i], vs[i], lat, bcnt);
      n_checks++;
      if (lat != 5 || bcnt != 4) begin
        n_fail++;
        $display("FAIL directed_timing[%0d]: latency=%0d busy_cycles=%0d, want 5 and 4", i, lat, bcnt);
      end
      n_checks++;
      if ({result, cout, overflow} !== ve[i]) begin
        n_fail++;
        $display("FAIL directed_value[%0d]: result=%h cout=%b ovf=%b, want %h %b %b",
                 i, result, cout, overflow, ve[i][17:2], ve[i][1], ve[i][0]);
      end
      if (i == 0) begin
        @(posedge clk); #1;
        n_checks++;
        if ({done, busy, result} !== {2'b00, 16'h0100}) begin
          n_fail++;
          $display("FAIL done_pulse_hold: done=%b busy=%b result=%h, want 0 0 0100", done, busy, result);
        end
      end
    end
  endtask

  task automatic test_random();
    int lat, bcnt;
    logic [15:0] a, b;
    logic sub;
    logic [17:0] exp;
    for (int i = 0; i < 40; i++) begin
      a = 16'($urandom); b = 16'($urandom); sub = 1'($urandom);
      if (i % 8 == 0) a = 16'h8000;
      if (i % 8 == 1) b = 16'hFFFF;
      exp = model(a, b, sub);
      do_op(a, b, sub, lat, bcnt);
      n_checks++;
      if (lat != 5 || {result, cout, overflow} !== exp) begin
        n_fail++;
        $display("FAIL random[%0d] %h %s %h: latency=%0d result=%h cout=%b ovf=%b, want 5 %h %b %b",
                 i, a, sub ? "-" : "+", b, lat, result, cout, overflow, exp[17:2], exp[1], exp[0]);
      end
    end
  endtask

  task automatic test_ignore_start();
    int lat;
    @(posedge clk); #1;
    start = 1'b1; a_in = 16'h1000; b_in = 16'h0234; op_sub = 1'b0;
    @(posedge clk); #1;
    lat = 1;
    while (!done && lat < 20) begin
      start = (lat == 2);
      a_in = 16'($urandom); b_in = 16'($urandom); op_sub = 1'($urandom);
      @(posedge clk); #1;
      lat++;
    end
    start = 1'b0;
    n_checks++;
    if (lat != 5 || {result, cout, overflow} !== {16'h1234, 2'b00}) begin
      n_fail++;
      $display("FAIL ignore_start: latency=%0d result=%h cout=%b ovf=%b, want 5 1234 0 0", lat, result, cout, overflow);
    end
    @(posedge clk); #1;
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL ignore_start_idle: busy=%b, want 0", busy);
    end
  endtask

  task automatic test_back_to_back();
    int lat, bcnt;
    do_op(16'h0F0F, 16'h0101, 1'b0, lat, bcnt);
    n_checks++;
    if (lat != 5 || result !== 16'h1010) begin
      n_fail++;
      $display("FAIL b2b_first: latency=%0d result=%h, want 5 1010", lat, result);
    end
    start = 1'b1; a_in = 16'h1234; b_in = 16'h1111; op_sub = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    n_checks++;
    if ({busy, done} !== 2'b10) begin
      n_fail++;
      $display("FAIL b2b_restart: busy=%b done=%b, want 1 0", busy, done);
    end
    lat = 1;
    while (!done && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    n_checks++;
    if (lat != 5 || {result, cout, overflow} !== {16'h2345, 2'b00}) begin
      n_fail++;
      $display("FAIL b2b_second: latency=%0d result=%h cout=%b ovf=%b, want 5 2345 0 0", lat, result, cout, overflow);
    end
  endtask

  task automatic test_reset_abort();
    int lat, bcnt;
    logic saw_done;
    @(posedge clk); #1;
    start = 1'b1; a_in = 16'hFFFF; b_in = 16'h0001; op_sub = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    n_checks++;
    if ({busy, done, result, cout, overflow} !== 20'h0) begin
      n_fail++;
      $display("FAIL abort_clear: busy=%b done=%b result=%h cout=%b ovf=%b, want all 0", busy, done, result, cout, overflow);
    end
    saw_done = 1'b0;
    repeat (8) begin
      @(posedge clk); #1;
      saw_done |= done | busy;
    end
    n_checks++;
    if (saw_done !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_quiet: activity=%b after abort, want 0", saw_done);
    end
    do_op(16'h0003, 16'h0004, 1'b0, lat, bcnt);
    n_checks++;
    if (lat != 5 || {result, cout, overflow} !== {16'h0007, 2'b00}) begin
      n_fail++;
      $display("FAIL abort_recover: latency=%0d result=%h, want 5 0007", lat, result);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_ignore_start();
    test_back_to_back();
    test_reset_abort();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
